divisor_param: RTL and testbench
================================

Name: divisor_param

Overview:
Parametrised sequential integer divider, the next generation of the team's fixed 16-bit restoring divider.
- Adds configurable operand width, a per-operation signed/unsigned mode, divide-by-zero detection and signed-overflow detection.
- Uses the same start/ready/done_tick handshake, so it drops into existing datapaths in place of the 16-bit unit.
- Radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
- LARGURA, 16, operand/result width in bits (legal range 4..32).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only while ready=1.
- sinal  in  1  mode for this operation: 1 = two's-complement signed, 0 = unsigned; latched with operands.
- dividendo  in  LARGURA  dividend.
- divisor  in  LARGURA  divisor.
- ready  out  1  high only in IDLE.
- done_tick  out  1  one-cycle pulse; results valid.
- quociente  out  LARGURA  quotient.
- resto  out  LARGURA  remainder.
- div_zero  out  1  last operation had divisor = 0.
- overflow  out  1  last operation was signed MIN / -1.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-operation): state to IDLE, iteration counter cleared; quociente=0, resto=0, div_zero=0, overflow=0, done_tick=0. ready=1 in the cycle after the reset edge. An in-flight operation is discarded.
- Clock edges are numbered from the one that samples start=1 with ready=1 (edge 0).
- States and transitions:
  - IDLE: ready=1. On start, latch dividendo, divisor and sinal; go to PREP.
  - PREP: form magnitudes. Signed mode: abs() of each operand; record result signs (quotient negative iff operand signs differ, remainder takes the dividend sign). Unsigned mode: operands unchanged. If divisor = 0, go to DONE at edge 1; otherwise load the partial remainder with 0, the shift register with |dividendo| and the counter with LARGURA, and go to DIV at edge 1.
  - DIV: each edge performs one iteration: shift {rem,quo} left, trial subtract |divisor| at LARGURA+1 bits, keep the result if non-negative and set the quotient LSB to 1, otherwise restore. Iterations run at edges 2..LARGURA+1; the counter reaching 0 moves the FSM to FIX.
  - FIX: at edge LARGURA+2, apply the recorded signs (two's-complement negate), write quociente/resto/div_zero=0/overflow, go to DONE.
  - DONE: done_tick=1 for exactly this one cycle; next edge goes to IDLE.
- Latency: normal operation has done_tick high in the cycle after edge LARGURA+2 (edge 18 for LARGURA=16). Divide-by-zero has done_tick high in the cycle after edge 1. ready returns one cycle after done_tick, so back-to-back throughput is one operation per LARGURA+4 cycles.
- Divide by zero: quociente = all ones, resto = latched dividendo, div_zero=1, overflow=0. The rule is the same in both modes.
- Signed overflow (dividend = 100..0, divisor = all ones, sinal=1): the natural computation yields quociente = 100..0 (wraps) and resto=0; flag overflow=1. |MIN| must be handled as an unsigned LARGURA-bit magnitude with no extra bit lost.
- Signed semantics: quotient truncates toward zero; remainder is zero or carries the dividend's sign; |resto| < |divisor|.
- Outputs and flags are registered and update only at the FIX edge (or the PREP edge for divide-by-zero). They hold the last result until the next completion or reset.
- start while not IDLE is ignored; operand and mode inputs may change freely after edge 0.
- start held high continuously: a new operation begins on the first IDLE cycle after DONE.
- rst and start both high at the same edge: reset wins.

Test Plan:
- LARGURA=16, unsigned 40/2, then 350/17 back-to-back with start held high -> q=20 r=0, then q=20 r=10. Each done_tick is a single cycle at edge 18 of its operation; ready=0 from edge 0 until the cycle after done_tick.
- Signed: -7/2 -> q=0xFFFD r=0xFFFF. 7/-2 -> q=0xFFFD r=0x0001. -7/-2 -> q=0x0003 r=0xFFFF. Unsigned 0xFFFF/1 -> q=0xFFFF r=0. All with div_zero=0, overflow=0.
- 100/0, both modes -> done_tick in the cycle after edge 1; q=0xFFFF r=100 div_zero=1. A following 60/4 clears the flag -> q=15 r=0 div_zero=0.
- Signed 0x8000/0xFFFF -> q=0x8000 r=0 overflow=1. The same operands unsigned -> q=0 r=0x8000 overflow=0.
- Reset and busy-start handling:
  - Start 300/15, assert rst at edge 8 -> no done_tick; outputs 0; ready=1 the next cycle.
  - Then start 240/12 -> q=20 r=0.
  - A start pulse with other operands during DIV is ignored.
- Second instance with LARGURA=8: unsigned 200/7 -> q=28 r=4, done_tick after edge 10. Signed 0x80/0x03 -> q=0xD6 (-42) r=0xFE (-2).

Source files
------------

// File: rtl/divisor_param_if.sv
// Handshake and operand/result bundle for the parametrised sequential divider.
// The master side requests operations; the slave side is the divider itself.
interface divisor_param_if #(
    parameter int LARGURA = 16
) ();
    logic               start;
    logic               sinal;
    logic [LARGURA-1:0] dividendo;
    logic [LARGURA-1:0] divisor;
    logic               ready;
    logic               done_tick;
    logic [LARGURA-1:0] quociente;
    logic [LARGURA-1:0] resto;
    logic               div_zero;
    logic               overflow;

    modport master (
        output start, sinal, dividendo, divisor,
        input  ready, done_tick, quociente, resto, div_zero, overflow
    );

    modport slave (
        input  start, sinal, dividendo, divisor,
        output ready, done_tick, quociente, resto, div_zero, overflow
    );
endinterface

// File: rtl/divisor_param.sv
// Radix-2 restoring divider, one quotient bit per clock, signed/unsigned per operation.
// Results and flags are registered and held until the next completion or reset.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready=1, waiting for start; operands and mode latched on start
// S_PREP | form magnitudes and result signs, catch divide-by-zero
// S_DIV  | one shift/trial-subtract iteration per clock, counter counts down
// S_FIX  | apply signs, write quotient/remainder/flags
// S_DONE | done_tick high for this single cycle
module divisor_param #(
    parameter int LARGURA = 16
) (
    input  logic         clk,
    input  logic         rst,
    divisor_param_if.slave bus
);

    localparam int CW = $clog2(LARGURA + 1);
    localparam logic [CW-1:0]      CNT_INIT = CW'(LARGURA);
    localparam logic [LARGURA-1:0] MIN_VAL  = {1'b1, {(LARGURA-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q,      state_d;
    logic [CW-1:0]      cnt_q,        cnt_d;
    logic [LARGURA-1:0] a_q,          a_d;
    logic [LARGURA-1:0] b_q,          b_d;
    logic               sinal_q,      sinal_d;
    logic [LARGURA-1:0] mag_b_q,      mag_b_d;
    logic [LARGURA-1:0] rem_q,        rem_d;
    logic [LARGURA-1:0] quo_q,        quo_d;
    logic               neg_quo_q,    neg_quo_d;
    logic               neg_rem_q,    neg_rem_d;
    logic               ovf_pend_q,   ovf_pend_d;
    logic [LARGURA-1:0] quociente_q,  quociente_d;
    logic [LARGURA-1:0] resto_q,      resto_d;
    logic               div_zero_q,   div_zero_d;
    logic               overflow_q,   overflow_d;
    logic               done_tick_q,  done_tick_d;
    logic               ready_q,      ready_d;

    logic [LARGURA-1:0] mag_a;
    logic [LARGURA-1:0] mag_b;
    logic [LARGURA:0]   shifted;
    logic [LARGURA:0]   trial;

    always_comb begin
        // |MIN| is 100..0 read as unsigned, so the LARGURA-bit negate loses nothing.
        mag_a = (sinal_q && a_q[LARGURA-1]) ? -a_q : a_q;
        mag_b = (sinal_q && b_q[LARGURA-1]) ? -b_q : b_q;

        // Remainder stays below |divisor|, so the shifted value fits LARGURA+1 bits
        // and the MSB of the trial difference is its sign.
        shifted = {rem_q, quo_q[LARGURA-1]};
        trial   = shifted - {1'b0, mag_b_q};

        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sinal_d     = sinal_q;
        mag_b_d     = mag_b_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        ovf_pend_d  = ovf_pend_q;
        quociente_d = quociente_q;
        resto_d     = resto_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.dividendo;
                    b_d     = bus.divisor;
                    sinal_d = bus.sinal;
                    state_d = S_PREP;
                end
            end

            S_PREP: begin
                neg_quo_d  = sinal_q && (a_q[LARGURA-1] ^ b_q[LARGURA-1]);
                neg_rem_d  = sinal_q && a_q[LARGURA-1];
                ovf_pend_d = sinal_q && (a_q == MIN_VAL) && (b_q == '1);
                if (b_q == '0) begin
                    quociente_d = '1;
                    resto_d     = a_q;
                    div_zero_d  = 1'b1;
                    overflow_d  = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    rem_d   = '0;
                    quo_d   = mag_a;
                    mag_b_d = mag_b;
                    cnt_d   = CNT_INIT;
                    state_d = S_DIV;
                end
            end

            S_DIV: begin
                if (!trial[LARGURA]) begin
                    rem_d = trial[LARGURA-1:0];
                    quo_d = {quo_q[LARGURA-2:0], 1'b1};
                end else begin
                    rem_d = shifted[LARGURA-1:0];
                    quo_d = {quo_q[LARGURA-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_d == '0) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                quociente_d = neg_quo_q ? -quo_q : quo_q;
                resto_d     = neg_rem_q ? -rem_q : rem_q;
                div_zero_d  = 1'b0;
                overflow_d  = ovf_pend_q;
                state_d     = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_tick_d = (state_d == S_DONE);
        ready_d     = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sinal_q     <= 1'b0;
            mag_b_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quociente_q <= '0;
            resto_q     <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
            done_tick_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sinal_q     <= sinal_d;
            mag_b_q     <= mag_b_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            ovf_pend_q  <= ovf_pend_d;
            quociente_q <= quociente_d;
            resto_q     <= resto_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
            done_tick_q <= done_tick_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done_tick = done_tick_q;
    assign bus.quociente = quociente_q;
    assign bus.resto     = resto_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_divisor_param.sv
// Bench for divisor_param: 16-bit and 8-bit instances, directed table, corner
// sequences and random operations checked against a plain-arithmetic model.
module tb_divisor_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divisor_param_if #(.LARGURA(16)) b16 ();
    divisor_param_if #(.LARGURA(8))  b8 ();

    divisor_param #(.LARGURA(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    divisor_param #(.LARGURA(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          s;
        logic [15:0] q;
        logic [15:0] r;
        bit          dz;
        bit          ov;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed division in SV truncates toward zero, % follows dividend sign.
    function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                  input bit s, output longint unsigned q, output longint unsigned r,
                                  output bit dz, output bit ov);
        longint mask;
        longint sa, sb, sq, sr;
        mask = (longint'(1) << w) - 1;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q  = mask;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
            sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
            sq = sa / sb;
            sr = sa % sb;
            ov = (sa == -(longint'(1) << (w-1))) && (sb == -1);
            q  = sq & mask;
            r  = sr & mask;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic get_ready(input bit w8);
        return w8 ? b8.ready : b16.ready;
    endfunction

    function automatic logic get_done(input bit w8);
        return w8 ? b8.done_tick : b16.done_tick;
    endfunction

    task automatic drive(input bit w8, input logic st, input logic [15:0] a,
                         input logic [15:0] b, input bit s);
        if (w8) begin
            b8.start = st; b8.dividendo = a[7:0]; b8.divisor = b[7:0]; b8.sinal = s;
        end else begin
            b16.start = st; b16.dividendo = a; b16.divisor = b; b16.sinal = s;
        end
    endtask

    // One operation; lat = edge number of the done_tick cycle (-1 if none within budget).
    task automatic run(input bit w8, input logic [15:0] a, input logic [15:0] b, input bit s,
                       input int inject, output logic [15:0] q, output logic [15:0] r,
                       output bit dz, output bit ov, output int lat);
        int guard;
        bit busy_ok;
        guard = 0;
        @(negedge clk);
        while (!get_ready(w8) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_start", get_ready(w8), 1);
        drive(w8, 1'b1, a, b, s);
        @(posedge clk);
        @(negedge clk);
        drive(w8, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        busy_ok = !get_ready(w8);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == inject) drive(w8, 1'b1, 16'd999, 16'd3, 1'b0);
            if (k == inject + 1) drive(w8, 1'b0, 16'd0, 16'd0, 1'b0);
            if (get_done(w8)) begin
                lat = k;
                break;
            end
            if (get_ready(w8)) busy_ok = 1'b0;
        end
        if (w8) begin
            q = {8'h00, b8.quociente}; r = {8'h00, b8.resto}; dz = b8.div_zero; ov = b8.overflow;
        end else begin
            q = b16.quociente; r = b16.resto; dz = b16.div_zero; ov = b16.overflow;
        end
        chk("ready_low_while_busy", busy_ok, 1);
        @(posedge clk);
        @(negedge clk);
        chk("done_single_cycle", get_done(w8), 0);
        chk("ready_after_done", get_ready(w8), 1);
    endtask

    vec_t vecs[$];
    logic [15:0] q, r;
    bit dz, ov;
    int lat;

    initial begin
        vecs.push_back('{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 18});
        vecs.push_back('{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 18});
        vecs.push_back('{16'hFFF9, 16'hFFFE, 1'b1, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 18});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 18});
        vecs.push_back('{16'd100,  16'd0,    1'b0, 16'hFFFF, 16'd100,  1'b1, 1'b0, 1});
        vecs.push_back('{16'd100,  16'd0,    1'b1, 16'hFFFF, 16'd100,  1'b1, 1'b0, 1});
        vecs.push_back('{16'd60,   16'd4,    1'b0, 16'd15,   16'd0,    1'b0, 1'b0, 18});
        vecs.push_back('{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 18});
        vecs.push_back('{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, 18});
        vecs.push_back('{16'd240,  16'd12,   1'b0, 16'd20,   16'd0,    1'b0, 1'b0, 18});

        rst = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", b16.ready, 1);
        chk("rst_q", b16.quociente, 0);
        chk("rst_r", b16.resto, 0);
        chk("rst_dz", b16.div_zero, 0);
        chk("rst_ov", b16.overflow, 0);
        chk("rst_done", b16.done_tick, 0);
        chk("rst_ready8", b8.ready, 1);

        // Back-to-back with start held high: 40/2 then 350/17.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'd40, 16'd2, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 16'd350, 16'd17, 1'b0);
        chk("b2b_busy1", b16.ready, 0);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (b16.done_tick) begin lat = k; break; end
        end
        chk("b2b_lat1", lat, 18);
        chk("b2b_q1", b16.quociente, 20);
        chk("b2b_r1", b16.resto, 0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_ready_idle", b16.ready, 1);
        chk("b2b_done_low", b16.done_tick, 0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        chk("b2b_busy2", b16.ready, 0);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (b16.done_tick) begin lat = k; break; end
        end
        chk("b2b_lat2", lat, 18);
        chk("b2b_q2", b16.quociente, 20);
        chk("b2b_r2", b16.resto, 10);

        foreach (vecs[i]) begin
            run(1'b0, vecs[i].a, vecs[i].b, vecs[i].s, 0, q, r, dz, ov, lat);
            chk($sformatf("vec%0d_q", i), q, vecs[i].q);
            chk($sformatf("vec%0d_r", i), r, vecs[i].r);
            chk($sformatf("vec%0d_dz", i), dz, vecs[i].dz);
            chk($sformatf("vec%0d_ov", i), ov, vecs[i].ov);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // Reset mid-operation at edge 8 discards 300/15.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'd300, 16'd15, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", b16.ready, 1);
        chk("midrst_q", b16.quociente, 0);
        chk("midrst_r", b16.resto, 0);
        chk("midrst_dz", b16.div_zero, 0);
        chk("midrst_done", b16.done_tick, 0);
        dz = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (b16.done_tick) dz = 1'b1;
        end
        chk("midrst_no_done", dz, 0);

        // 240/12 with a start pulse of 999/3 injected during DIV.
        run(1'b0, 16'd240, 16'd12, 1'b0, 5, q, r, dz, ov, lat);
        chk("busy_start_q", q, 20);
        chk("busy_start_r", r, 0);
        chk("busy_start_lat", lat, 18);
        repeat (3) @(negedge clk);
        chk("busy_start_still_idle", b16.ready, 1);

        run(1'b1, 16'd200, 16'd7, 1'b0, 0, q, r, dz, ov, lat);
        chk("w8_q", q, 28);
        chk("w8_r", r, 4);
        chk("w8_lat", lat, 10);
        run(1'b1, 16'h0080, 16'h0003, 1'b1, 0, q, r, dz, ov, lat);
        chk("w8s_q", q, 16'h00D6);
        chk("w8s_r", r, 16'h00FE);
        chk("w8s_ov", ov, 0);

        for (int i = 0; i < 240; i++) begin
            bit w8, s;
            int w, mode;
            logic [15:0] a, b;
            longint unsigned eq, er;
            bit edz, eov;
            w8   = (i % 3 == 0);
            w    = w8 ? 8 : 16;
            a    = 16'($urandom);
            b    = 16'($urandom);
            s    = 1'($urandom);
            mode = $urandom_range(0, 9);
            if (mode == 0) b = 16'd0;
            if (mode == 1) begin
                a = w8 ? 16'h0080 : 16'h8000;
                b = 16'hFFFF;
                s = 1'b1;
            end
            if (mode == 2) b = 16'($urandom_range(1, 5));
            if (mode == 3) b = 16'hFFFF - 16'($urandom_range(0, 3));
            if (w8) begin
                a = {8'h00, a[7:0]};
                b = {8'h00, b[7:0]};
            end
            model(w, a, b, s, eq, er, edz, eov);
            run(w8, a, b, s, 0, q, r, dz, ov, lat);
            chk($sformatf("rnd%0d_q", i), q, eq);
            chk($sformatf("rnd%0d_r", i), r, er);
            chk($sformatf("rnd%0d_dz", i), dz, edz);
            chk($sformatf("rnd%0d_ov", i), ov, eov);
            chk($sformatf("rnd%0d_lat", i), lat, edz ? 1 : w + 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
